reg_file: RTL

Architectural register file with rename-tag tracking for the out-of-order RISC-V core. It is the consumer of the reorder buffer's commit port and holds committed `x0..x31` values plus, per register, the reorder-buffer entry that will next write it. It answers issuer operand lookups combinationally: either a committed value or a producer tag, with same-cycle commit bypass. It records rename tags at issue, retires them at commit, and clears all tags on a rob-bus flush.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_read_port.sv | 35 +++
 rtl/reg_file.sv | 85 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the architectural register file.
package reg_file_pkg;

   localparam int unsigned XLEN         = 32;
   localparam int unsigned REG_COUNT    = 32;
   localparam int unsigned REG_ID_WIDTH = $clog2(REG_COUNT);
   localparam int unsigned ROB_ID_WIDTH = 5;

   typedef logic [XLEN-1:0]         REG_TYPE;
   typedef logic [REG_ID_WIDTH-1:0] REG_ID_TYPE;
   typedef logic [ROB_ID_WIDTH-1:0] RO_BUFFER_ID_TYPE;

   // ROB id 0 means "no producer" / "no commit".
   localparam RO_BUFFER_ID_TYPE NULL_ROB_ID = '0;
   localparam REG_ID_TYPE       ZERO_REG    = '0;

endpackage

// File: rtl/reg_read_port.sv
// One operand lookup: hardwired x0, same-cycle commit bypass, tag or stored value.
module reg_read_port
   import reg_file_pkg::*;
(
   input  logic [REG_ID_WIDTH-1:0] rs,
   input  logic [ROB_ID_WIDTH-1:0] rs_tag,
   input  logic [XLEN-1:0]         rs_value,
   input  logic                    commit,
   input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
   input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
   input  logic [XLEN-1:0]         value_from_rob,
   output logic [ROB_ID_WIDTH-1:0] q,
   output logic [XLEN-1:0]         v
);

   // Select producer tag or value; a matching commit makes the operand ready this cycle.
   always_comb begin
      q = NULL_ROB_ID;
      v = '0;
      if (rs == ZERO_REG) begin
         q = NULL_ROB_ID;
         v = '0;
      end else if (commit && (rd_from_rob == rs) && (rs_tag == dest_from_rob)) begin
         q = NULL_ROB_ID;
         v = value_from_rob;
      end else if (rs_tag != NULL_ROB_ID) begin
         q = rs_tag;
         v = '0;
      end else begin
         q = NULL_ROB_ID;
         v = rs_value;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags and commit bypass.
module reg_file
   import reg_file_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rdy,
   input  logic                    reset_from_rob_bus,
   input  logic                    valid_from_issuer,
   input  logic [REG_ID_WIDTH-1:0] rd_from_issuer,
   input  logic [ROB_ID_WIDTH-1:0] dest_from_issuer,
   input  logic [REG_ID_WIDTH-1:0] rs1_from_issuer,
   input  logic [REG_ID_WIDTH-1:0] rs2_from_issuer,
   output logic [ROB_ID_WIDTH-1:0] qj_to_issuer,
   output logic [ROB_ID_WIDTH-1:0] qk_to_issuer,
   output logic [XLEN-1:0]         vj_to_issuer,
   output logic [XLEN-1:0]         vk_to_issuer,
   input  logic [ROB_ID_WIDTH-1:0] dest_from_rob,
   input  logic [REG_ID_WIDTH-1:0] rd_from_rob,
   input  logic [XLEN-1:0]         value_from_rob
);

   REG_TYPE          value_q [REG_COUNT];
   RO_BUFFER_ID_TYPE tag_q   [REG_COUNT];

   logic commit;
   logic rename;

   // x0 is never a commit or rename target, so its entries stay at their reset value.
   assign commit = (dest_from_rob != NULL_ROB_ID) && (rd_from_rob != ZERO_REG);
   assign rename = valid_from_issuer && (rd_from_issuer != ZERO_REG);

   // Storage update: reset, then commit value write, then flush or tag retire/rename.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            value_q[i] <= '0;
            tag_q[i]   <= NULL_ROB_ID;
         end
      end else if (rdy) begin
         if (commit) begin
            value_q[rd_from_rob] <= value_from_rob;
         end
         if (reset_from_rob_bus) begin
            for (int i = 0; i < REG_COUNT; i++) begin
               tag_q[i] <= NULL_ROB_ID;
            end
         end else begin
            // Only retire the tag if no younger rename has replaced it.
            if (commit && (tag_q[rd_from_rob] == dest_from_rob)) begin
               tag_q[rd_from_rob] <= NULL_ROB_ID;
            end
            // Later assignment wins when rename and commit target the same register.
            if (rename) begin
               tag_q[rd_from_issuer] <= dest_from_issuer;
            end
         end
      end
   end

   reg_read_port u_read_j (
      .rs             (rs1_from_issuer),
      .rs_tag         (tag_q[rs1_from_issuer]),
      .rs_value       (value_q[rs1_from_issuer]),
      .commit         (commit),
      .rd_from_rob    (rd_from_rob),
      .dest_from_rob  (dest_from_rob),
      .value_from_rob (value_from_rob),
      .q              (qj_to_issuer),
      .v              (vj_to_issuer)
   );

   reg_read_port u_read_k (
      .rs             (rs2_from_issuer),
      .rs_tag         (tag_q[rs2_from_issuer]),
      .rs_value       (value_q[rs2_from_issuer]),
      .commit         (commit),
      .rd_from_rob    (rd_from_rob),
      .dest_from_rob  (dest_from_rob),
      .value_from_rob (value_from_rob),
      .q              (qk_to_issuer),
      .v              (vk_to_issuer)
   );

endmodule
